// File: rtl/vedic_pkg.sv
// Shared widths and inter-stage bundles for the 8x8 Vedic multiplier.
package vedic_pkg;

   localparam int HALF   = 4;
   localparam int PP_W   = 8;
   localparam int MID_W  = 9;
   localparam int PROD_W = 16;

   typedef struct packed {
      logic [PP_W-1:0] ll;
      logic [PP_W-1:0] lh;
      logic [PP_W-1:0] hl;
      logic [PP_W-1:0] hh;
   } s1_t;

   typedef struct packed {
      logic [MID_W-1:0] mid;
      logic [PP_W-1:0]  ll;
      logic [PP_W-1:0]  hh;
   } s2_t;

endpackage

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder; the only adder used in the multiplier.
module cla_adder_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum_o  = p ^ c[3:0];
   assign cout_o = c[4];

endmodule

// File: rtl/vedic_mul_4x4.sv
// Combinational 4x4 -> 8 multiplier: AND rows folded by a chain of CLAs.
module vedic_mul_4x4
   import vedic_pkg::*;
(
   input  logic [HALF-1:0] a_i,
   input  logic [HALF-1:0] b_i,
   output logic [PP_W-1:0] p_o
);

   logic [3:0] r0, r1, r2, r3;
   logic [3:0] s1, s2, s3;
   logic       c1, c2, c3;

   assign r0 = a_i & {HALF{b_i[0]}};
   assign r1 = a_i & {HALF{b_i[1]}};
   assign r2 = a_i & {HALF{b_i[2]}};
   assign r3 = a_i & {HALF{b_i[3]}};

   // Each row retires its LSB; the rest shifts down into the next add.
   cla_adder_4bit u_add1 (
      .a_i   ({1'b0, r0[3:1]}),
      .b_i   (r1),
      .cin_i (1'b0),
      .sum_o (s1),
      .cout_o(c1)
   );

   cla_adder_4bit u_add2 (
      .a_i   ({c1, s1[3:1]}),
      .b_i   (r2),
      .cin_i (1'b0),
      .sum_o (s2),
      .cout_o(c2)
   );

   cla_adder_4bit u_add3 (
      .a_i   ({c2, s2[3:1]}),
      .b_i   (r3),
      .cin_i (1'b0),
      .sum_o (s3),
      .cout_o(c3)
   );

   assign p_o = {c3, s3, s2[0], s1[0], r0[0]};

endmodule

// File: rtl/vedic_mul_8x8_pipe.sv
// 8x8 unsigned Urdhva-Tiryagbhyam multiplier, 3-stage valid/ready pipeline.
module vedic_mul_8x8_pipe
   import vedic_pkg::*;
#(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_a,
   input  logic [W-1:0]      in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_prod
);

   if (W != 8) begin : g_bad_w
      $error("vedic_mul_8x8_pipe: only W=8 is supported");
   end

   s1_t               s1_d, s1_q;
   s2_t               s2_d, s2_q;
   logic [PROD_W-1:0] prod_d, prod_q;
   logic              v1_q, v2_q, v3_q;
   logic              stall;

   assign stall     = v3_q && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = v3_q;
   assign out_prod  = prod_q;

   vedic_mul_4x4 u_ll (.a_i(in_a[3:0]), .b_i(in_b[3:0]), .p_o(s1_d.ll));
   vedic_mul_4x4 u_lh (.a_i(in_a[3:0]), .b_i(in_b[7:4]), .p_o(s1_d.lh));
   vedic_mul_4x4 u_hl (.a_i(in_a[7:4]), .b_i(in_b[3:0]), .p_o(s1_d.hl));
   vedic_mul_4x4 u_hh (.a_i(in_a[7:4]), .b_i(in_b[7:4]), .p_o(s1_d.hh));

   logic [3:0] m_lo, m_hi;
   logic       m_c0, m_c1;

   cla_adder_4bit u_mid_lo (
      .a_i   (s1_q.lh[3:0]),
      .b_i   (s1_q.hl[3:0]),
      .cin_i (1'b0),
      .sum_o (m_lo),
      .cout_o(m_c0)
   );

   cla_adder_4bit u_mid_hi (
      .a_i   (s1_q.lh[7:4]),
      .b_i   (s1_q.hl[7:4]),
      .cin_i (m_c0),
      .sum_o (m_hi),
      .cout_o(m_c1)
   );

   assign s2_d.mid = {m_c1, m_hi, m_lo};
   assign s2_d.ll  = s1_q.ll;
   assign s2_d.hh  = s1_q.hh;

   logic [PROD_W-1:0] op_a, op_b;
   logic [2:0]        pc;
   logic              carry_unused;

   assign op_a = {s2_q.hh, s2_q.ll};
   assign op_b = {3'b000, s2_q.mid, 4'b0000};

   cla_adder_4bit u_sum0 (
      .a_i(op_a[3:0]), .b_i(op_b[3:0]), .cin_i(1'b0),
      .sum_o(prod_d[3:0]), .cout_o(pc[0])
   );

   cla_adder_4bit u_sum1 (
      .a_i(op_a[7:4]), .b_i(op_b[7:4]), .cin_i(pc[0]),
      .sum_o(prod_d[7:4]), .cout_o(pc[1])
   );

   cla_adder_4bit u_sum2 (
      .a_i(op_a[11:8]), .b_i(op_b[11:8]), .cin_i(pc[1]),
      .sum_o(prod_d[11:8]), .cout_o(pc[2])
   );

   // 255*255 fits in 16 bits, so this carry can never be set.
   cla_adder_4bit u_sum3 (
      .a_i(op_a[15:12]), .b_i(op_b[15:12]), .cin_i(pc[2]),
      .sum_o(prod_d[15:12]), .cout_o(carry_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
         prod_q <= '0;
      end else if (!stall) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (in_valid) s1_q   <= s1_d;
         if (v1_q)     s2_q   <= s2_d;
         if (v2_q)     prod_q <= prod_d;
      end
   end

endmodule

// File: tb/tb_vedic_mul_8x8_pipe.sv
// Self-checking bench: directed cases plus random traffic vs a queue model.
module tb_vedic_mul_8x8_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_prod;

   always #5 clk = ~clk;

   vedic_mul_8x8_pipe #(.W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_prod (out_prod)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          lat_on = 1'b0;
   logic [15:0] exp_q[$];
   int          acc_q[$];
   logic [15:0] got_q[$];
   int          got_cyc[$];
   logic        prev_hold = 1'b0;
   logic [15:0] prev_prod = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         prev_hold = 1'b0;
      end else begin
         chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_prod", 32'(out_prod), 32'(prev_prod));
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("out_without_input", 32'(out_valid), 32'd0);
            end else begin
               chk("out_prod", 32'(out_prod), 32'(exp_q[0]));
               if (lat_on) chk("latency", 32'(cyc - acc_q[0]), 32'd3);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(acc_q.pop_front());
                  got_q.push_back(out_prod);
                  got_cyc.push_back(cyc);
               end
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_prod = out_prod;
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(int'(in_a) * int'(in_b)));
            acc_q.push_back(cyc);
         end
      end
   end

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(logic [7:0] a, logic [7:0] b);
      bit ok = 1'b0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (exp_q.size() != 0 || out_valid); k++)
         @(posedge clk);
      #1;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      idle(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n0;
      int sent;
      bit acc;
      logic [15:0] lit [3];

      out_ready = 1'b1;
      idle(2);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_prod", 32'(out_prod), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      idle(1);

      // 1: max operands
      lat_on = 1'b1;
      n0 = got_q.size();
      send(8'hFF, 8'hFF);
      drain();
      chk("t1_count", 32'(got_q.size() - n0), 32'd1);
      if (got_q.size() > n0) chk("t1_prod", 32'(got_q[n0]), 32'hFE01);

      // 2: back-to-back
      n0 = got_q.size();
      send(8'd13, 8'd11);
      send(8'h00, 8'hA5);
      send(8'h80, 8'h02);
      drain();
      chk("t2_count", 32'(got_q.size() - n0), 32'd3);
      lit[0] = 16'h008F;
      lit[1] = 16'h0000;
      lit[2] = 16'h0100;
      if (got_q.size() >= n0 + 3) begin
         for (int i = 0; i < 3; i++) chk("t2_prod", 32'(got_q[n0+i]), 32'(lit[i]));
         chk("t2_gap0", 32'(got_cyc[n0+1] - got_cyc[n0]), 32'd1);
         chk("t2_gap1", 32'(got_cyc[n0+2] - got_cyc[n0+1]), 32'd1);
      end

      // 3: full pipe, consumer stalls 5 cycles
      lat_on = 1'b0;
      out_ready = 1'b0;
      n0 = got_q.size();
      send(8'd1, 8'd2);
      send(8'd3, 8'd4);
      send(8'd5, 8'd6);
      repeat (5) begin
         @(negedge clk);
         chk("t3_in_ready", 32'(in_ready), 32'd0);
         chk("t3_valid", 32'(out_valid), 32'd1);
         chk("t3_frozen", 32'(out_prod), 32'd2);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      chk("t3_count", 32'(got_q.size() - n0), 32'd3);
      lit[0] = 16'd2;
      lit[1] = 16'd12;
      lit[2] = 16'd30;
      if (got_q.size() >= n0 + 3)
         for (int i = 0; i < 3; i++) chk("t3_prod", 32'(got_q[n0+i]), 32'(lit[i]));

      // 4: reset with three products in flight
      lat_on = 1'b1;
      n0 = got_q.size();
      send(8'd7, 8'd9);
      send(8'd200, 8'd100);
      send(8'd17, 8'd19);
      chk("t4_inflight", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", 32'(out_valid), 32'd0);
      chk("t4_rst_prod", 32'(out_prod), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(6);
      chk("t4_none_emitted", 32'(got_q.size()), 32'(n0));

      // 5: in_valid toggling every other cycle
      n0 = got_q.size();
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom), 8'($urandom));
         idle(1);
      end
      drain();
      chk("t5_count", 32'(got_q.size() - n0), 32'd6);
      if (got_q.size() >= n0 + 6)
         for (int i = 1; i < 6; i++)
            chk("t5_gap", 32'(got_cyc[n0+i] - got_cyc[n0+i-1]), 32'd2);

      // 6: random traffic with random back-pressure
      lat_on = 1'b0;
      sent = 0;
      acc = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 60000 && sent < 10000; k++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) sent++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("t6_sent", 32'(sent), 32'd10000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
